// File: rtl/flash_ctrl_pkg.sv
// flash_ctrl_pkg: shared state type and constants
// for the AHB flash window controller.
package flash_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ACC,
        WR_CAP,
        PROG_WAIT,
        ERR1,
        ERR2
    } fsm_state_e;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [31:0] FLASH_BASE = 32'h7000_0000;
    localparam logic [31:0] FLASH_SIZE = 32'h0008_0000;

    localparam int RD_WAIT_DEF      = 2;
    localparam int PROG_TIMEOUT_DEF = 1023;

endpackage

// File: rtl/ahb_flash_ctrl_rbuf.sv
// ahb_flash_ctrl_rbuf: single-entry read buffer
// with tag compare for zero-wait re-reads.
module ahb_flash_ctrl_rbuf #(
    parameter int ADDR_W = 17
) (
    input  logic              pll_core_cpuclk,
    input  logic              pad_cpu_rst_b,
    input  logic              load,
    input  logic              invalidate,
    input  logic [ADDR_W-1:0] load_tag,
    input  logic [31:0]       load_data,
    input  logic [ADDR_W-1:0] lookup_tag,
    output logic              hit,
    output logic [31:0]       rdata
);

    logic              valid_q;
    logic [ADDR_W-1:0] tag_q;
    logic [31:0]       data_q;

    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            tag_q   <= load_tag;
            data_q  <= load_data;
        end else if (invalidate) begin
            valid_q <= 1'b0;
        end
    end

    assign hit   = valid_q && (tag_q == lookup_tag);
    assign rdata = data_q;

endmodule

// File: rtl/ahb_flash_ctrl.sv
// ahb_flash_ctrl: AHB-lite word slave that turns bus
// reads/writes into NOR flash read and program cycles.
module ahb_flash_ctrl
    import flash_ctrl_pkg::*;
#(
    parameter int RD_WAIT      = RD_WAIT_DEF,
    parameter int PROG_TIMEOUT = PROG_TIMEOUT_DEF,
    parameter int ADDR_W       = $clog2(FLASH_SIZE) - 2
) (
    input  logic              pll_core_cpuclk,
    input  logic              pad_cpu_rst_b,
    input  logic              hsel_s4,
    input  logic [31:0]       haddr_s4,
    input  logic [1:0]        htrans_s4,
    input  logic              hwrite_s4,
    input  logic [31:0]       hwdata_s4,
    output logic [31:0]       hrdata_s4,
    output logic              hready_s4,
    output logic [1:0]        hresp_s4,
    output logic              flash_cs,
    output logic              flash_rd,
    output logic              flash_prog,
    output logic [ADDR_W-1:0] flash_addr,
    output logic [31:0]       flash_wdata,
    input  logic [31:0]       flash_rdata,
    input  logic              flash_busy
);

    localparam int TW = $clog2(PROG_TIMEOUT + 1);
    localparam logic [3:0]    RD_LAST = 4'(RD_WAIT);
    localparam logic [TW-1:0] TO_LAST = TW'(PROG_TIMEOUT - 1);

    fsm_state_e        state_q;
    fsm_state_e        state_d;
    logic [3:0]        rd_cnt_q;
    logic [TW-1:0]     to_cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       hrdata_q;
    logic              prog_q;

    logic              hready;
    logic [1:0]        hresp;
    logic              accept;
    logic              misalign;
    logic              rd_last;
    logic              buf_hit;
    logic [31:0]       buf_rdata;
    logic [ADDR_W-1:0] bus_addr;
    logic              unused_bits;

    assign bus_addr    = haddr_s4[ADDR_W+1:2];
    assign misalign    = |haddr_s4[1:0];
    assign rd_last     = (state_q == RD_ACC) && (rd_cnt_q == RD_LAST);
    assign unused_bits = ^{haddr_s4[31:ADDR_W+2], htrans_s4[0]};

    ahb_flash_ctrl_rbuf #(
        .ADDR_W (ADDR_W)
    ) u_rbuf (
        .pll_core_cpuclk (pll_core_cpuclk),
        .pad_cpu_rst_b   (pad_cpu_rst_b),
        .load            (rd_last),
        .invalidate      (state_q == WR_CAP),
        .load_tag        (addr_q),
        .load_data       (flash_rdata),
        .lookup_tag      (bus_addr),
        .hit             (buf_hit),
        .rdata           (buf_rdata)
    );

    always_comb begin
        state_d = state_q;
        hready  = 1'b1;
        hresp   = HRESP_OKAY;
        unique case (state_q)
            IDLE: ;
            RD_ACC: begin
                hready = 1'b0;
                if (rd_cnt_q == RD_LAST)
                    state_d = IDLE;
            end
            WR_CAP: begin
                hready  = 1'b0;
                state_d = PROG_WAIT;
            end
            PROG_WAIT: begin
                // busy is ignored in the pulse cycle itself
                if (to_cnt_q != '0 && !flash_busy) begin
                    state_d = IDLE;
                end else begin
                    hready = 1'b0;
                    if (to_cnt_q == TO_LAST)
                        state_d = ERR1;
                end
            end
            ERR1: begin
                hready  = 1'b0;
                hresp   = HRESP_ERROR;
                state_d = ERR2;
            end
            ERR2: begin
                hresp   = HRESP_ERROR;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        accept = hready && hsel_s4 && htrans_s4[1];
        if (accept) begin
            if (misalign)
                state_d = ERR1;
            else if (hwrite_s4)
                state_d = WR_CAP;
            else if (buf_hit)
                state_d = IDLE;
            else
                state_d = RD_ACC;
        end
    end

    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            state_q  <= IDLE;
            rd_cnt_q <= '0;
            to_cnt_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            hrdata_q <= '0;
            prog_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= (state_q == RD_ACC) ? rd_cnt_q + 4'd1 : '0;
            to_cnt_q <= (state_q == PROG_WAIT) ? to_cnt_q + 1'b1 : '0;
            prog_q   <= (state_q == WR_CAP);
            if (accept)
                addr_q <= bus_addr;
            if (state_q == WR_CAP)
                wdata_q <= hwdata_s4;
            if (rd_last)
                hrdata_q <= flash_rdata;
            else if (accept && !misalign && !hwrite_s4 && buf_hit)
                hrdata_q <= buf_rdata;
        end
    end

    assign hready_s4   = hready;
    assign hresp_s4    = hresp;
    assign hrdata_s4   = hrdata_q;
    assign flash_rd    = (state_q == RD_ACC);
    assign flash_cs    = flash_rd || prog_q;
    assign flash_prog  = prog_q;
    assign flash_addr  = flash_cs ? addr_q : '0;
    assign flash_wdata = prog_q ? wdata_q : '0;

endmodule

// File: tb/tb_ahb_flash_ctrl.sv
// tb_ahb_flash_ctrl: scoreboard bench for the flash
// controller with a small flash macro model.
module tb_ahb_flash_ctrl;

    logic        pll_core_cpuclk = 1'b0;
    logic        pad_cpu_rst_b   = 1'b0;
    logic        hsel_s4   = 1'b0;
    logic [31:0] haddr_s4  = '0;
    logic [1:0]  htrans_s4 = '0;
    logic        hwrite_s4 = 1'b0;
    logic [31:0] hwdata_s4 = '0;
    logic [31:0] hrdata_s4;
    logic        hready_s4;
    logic [1:0]  hresp_s4;
    logic        flash_cs;
    logic        flash_rd;
    logic        flash_prog;
    logic [16:0] flash_addr;
    logic [31:0] flash_wdata;
    logic [31:0] flash_rdata = '0;
    logic        flash_busy;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] sb[$];
    logic [31:0] fmem [0:63];
    int          busy_len   = 0;
    int          busy_left  = 0;
    logic        busy_stuck = 1'b0;
    int          rd_cycles  = 0;
    int          cs_cycles  = 0;
    int          prog_cycles = 0;
    logic [16:0] last_paddr = '0;
    logic [31:0] last_pdata = '0;

    always #5 pll_core_cpuclk = ~pll_core_cpuclk;

    ahb_flash_ctrl #(
        .RD_WAIT      (2),
        .PROG_TIMEOUT (8),
        .ADDR_W       (17)
    ) dut (
        .pll_core_cpuclk (pll_core_cpuclk),
        .pad_cpu_rst_b   (pad_cpu_rst_b),
        .hsel_s4         (hsel_s4),
        .haddr_s4        (haddr_s4),
        .htrans_s4       (htrans_s4),
        .hwrite_s4       (hwrite_s4),
        .hwdata_s4       (hwdata_s4),
        .hrdata_s4       (hrdata_s4),
        .hready_s4       (hready_s4),
        .hresp_s4        (hresp_s4),
        .flash_cs        (flash_cs),
        .flash_rd        (flash_rd),
        .flash_prog      (flash_prog),
        .flash_addr      (flash_addr),
        .flash_wdata     (flash_wdata),
        .flash_rdata     (flash_rdata),
        .flash_busy      (flash_busy)
    );

    // flash macro model: read port, program port, busy timer
    assign flash_busy = busy_stuck || (busy_left != 0);

    always @(negedge pll_core_cpuclk)
        flash_rdata <= flash_rd ? fmem[flash_addr[5:0]] : 32'h0;

    always @(posedge pll_core_cpuclk) begin
        if (flash_rd) rd_cycles <= rd_cycles + 1;
        if (flash_cs) cs_cycles <= cs_cycles + 1;
        if (flash_prog) begin
            prog_cycles <= prog_cycles + 1;
            last_paddr  <= flash_addr;
            last_pdata  <= flash_wdata;
            fmem[flash_addr[5:0]] <= flash_wdata;
            busy_left   <= busy_len;
        end else if (busy_left > 0) begin
            busy_left <= busy_left - 1;
        end
    end

    task automatic addr_phase(input logic wr,
                              input logic [31:0] a);
        hsel_s4   = 1'b1;
        htrans_s4 = 2'b10;
        hwrite_s4 = wr;
        haddr_s4  = a;
        @(posedge pll_core_cpuclk); #1;
        hsel_s4   = 1'b0;
        htrans_s4 = 2'b00;
        hwrite_s4 = 1'b0;
    endtask

    task automatic wait_ready(output int ws);
        ws = 0;
        @(negedge pll_core_cpuclk);
        while (!hready_s4 && ws < 2000) begin
            ws++;
            @(negedge pll_core_cpuclk);
        end
        if (!hready_s4) ws = -1;
    endtask

    task automatic next_cycle();
        @(posedge pll_core_cpuclk); #1;
    endtask

    task automatic test_reset();
        @(negedge pll_core_cpuclk);
        @(negedge pll_core_cpuclk);
        tests_run++;
        if ({hready_s4, hresp_s4, hrdata_s4} !== {1'b1, 2'b00, 32'h0}) begin
            tests_failed++;
            $display("FAIL reset_bus got rdy=%b resp=%b rdata=%h want 1/00/0",
                     hready_s4, hresp_s4, hrdata_s4);
        end
        tests_run++;
        if ({flash_cs, flash_rd, flash_prog, flash_addr, flash_wdata} !== '0) begin
            tests_failed++;
            $display("FAIL reset_flash got cs=%b rd=%b prog=%b a=%h d=%h want 0",
                     flash_cs, flash_rd, flash_prog, flash_addr, flash_wdata);
        end
        pad_cpu_rst_b = 1'b1;
        next_cycle();
    endtask

    task automatic test_read_miss_hit();
        int ws;
        int r0;
        logic [31:0] exp;
        r0 = rd_cycles;
        sb.push_back(32'hDEAD_BEEF);
        addr_phase(1'b0, 32'h7000_0010);
        wait_ready(ws);
        exp = sb.pop_front();
        tests_run++;
        if (ws !== 3) begin
            tests_failed++;
            $display("FAIL miss_ws got %0d want 3", ws);
        end
        tests_run++;
        if (hrdata_s4 !== exp || hresp_s4 !== 2'b00) begin
            tests_failed++;
            $display("FAIL miss_data got %h/%b want %h/00",
                     hrdata_s4, hresp_s4, exp);
        end
        tests_run++;
        if (rd_cycles - r0 !== 3) begin
            tests_failed++;
            $display("FAIL miss_rd_len got %0d want 3", rd_cycles - r0);
        end
        next_cycle();
        r0 = rd_cycles;
        sb.push_back(32'hDEAD_BEEF);
        addr_phase(1'b0, 32'h7000_0010);
        wait_ready(ws);
        exp = sb.pop_front();
        tests_run++;
        if (ws !== 0 || hrdata_s4 !== exp) begin
            tests_failed++;
            $display("FAIL hit got ws=%0d d=%h want 0/%h", ws, hrdata_s4, exp);
        end
        tests_run++;
        if (rd_cycles - r0 !== 0) begin
            tests_failed++;
            $display("FAIL hit_no_rd got %0d want 0", rd_cycles - r0);
        end
        next_cycle();
    endtask

    task automatic test_write();
        int ws;
        int p0;
        int r0;
        logic [31:0] exp;
        busy_len = 5;
        p0 = prog_cycles;
        addr_phase(1'b1, 32'h7000_0010);
        hwdata_s4 = 32'h1234_5678;
        wait_ready(ws);
        tests_run++;
        if (ws !== 7 || hresp_s4 !== 2'b00) begin
            tests_failed++;
            $display("FAIL wr_done got ws=%0d resp=%b want 7/00", ws, hresp_s4);
        end
        tests_run++;
        if (prog_cycles - p0 !== 1) begin
            tests_failed++;
            $display("FAIL wr_pulse got %0d want 1", prog_cycles - p0);
        end
        tests_run++;
        if (last_paddr !== 17'h4 || last_pdata !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL wr_addr_data got %h/%h want 4/12345678",
                     last_paddr, last_pdata);
        end
        next_cycle();
        busy_len = 0;
        r0 = rd_cycles;
        sb.push_back(32'h1234_5678);
        addr_phase(1'b0, 32'h7000_0010);
        wait_ready(ws);
        exp = sb.pop_front();
        tests_run++;
        if (ws !== 3 || hrdata_s4 !== exp || rd_cycles - r0 !== 3) begin
            tests_failed++;
            $display("FAIL wr_then_miss got ws=%0d d=%h rd=%0d want 3/%h/3",
                     ws, hrdata_s4, rd_cycles - r0, exp);
        end
        next_cycle();
    endtask

    task automatic test_misalign();
        int c0;
        c0 = cs_cycles;
        addr_phase(1'b0, 32'h7000_0002);
        @(negedge pll_core_cpuclk);
        tests_run++;
        if (hready_s4 !== 1'b0 || hresp_s4 !== 2'b01) begin
            tests_failed++;
            $display("FAIL err1 got rdy=%b resp=%b want 0/01", hready_s4, hresp_s4);
        end
        @(negedge pll_core_cpuclk);
        tests_run++;
        if (hready_s4 !== 1'b1 || hresp_s4 !== 2'b01) begin
            tests_failed++;
            $display("FAIL err2 got rdy=%b resp=%b want 1/01", hready_s4, hresp_s4);
        end
        @(negedge pll_core_cpuclk);
        tests_run++;
        if (hresp_s4 !== 2'b00 || cs_cycles - c0 !== 0) begin
            tests_failed++;
            $display("FAIL err_end got resp=%b cs=%0d want 00/0",
                     hresp_s4, cs_cycles - c0);
        end
        next_cycle();
    endtask

    task automatic test_timeout();
        int ws;
        logic [31:0] exp;
        busy_stuck = 1'b1;
        addr_phase(1'b1, 32'h7000_0020);
        hwdata_s4 = 32'h55AA_55AA;
        wait_ready(ws);
        tests_run++;
        if (ws !== 10 || hresp_s4 !== 2'b01) begin
            tests_failed++;
            $display("FAIL timeout got ws=%0d resp=%b want 10/01", ws, hresp_s4);
        end
        busy_stuck = 1'b0;
        @(negedge pll_core_cpuclk);
        tests_run++;
        if (hresp_s4 !== 2'b00 || hready_s4 !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_end got resp=%b rdy=%b want 00/1",
                     hresp_s4, hready_s4);
        end
        next_cycle();
        sb.push_back(32'h1234_5678);
        addr_phase(1'b0, 32'h7000_0010);
        wait_ready(ws);
        exp = sb.pop_front();
        tests_run++;
        if (ws !== 3 || hresp_s4 !== 2'b00 || hrdata_s4 !== exp) begin
            tests_failed++;
            $display("FAIL after_timeout got ws=%0d resp=%b d=%h want 3/00/%h",
                     ws, hresp_s4, hrdata_s4, exp);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        int ws;
        int r0;
        logic [31:0] exp;
        r0 = rd_cycles;
        sb.push_back(32'hC0DE_000C);
        addr_phase(1'b0, 32'h7000_0030);
        wait_ready(ws);
        exp = sb.pop_front();
        tests_run++;
        if (ws !== 3 || hrdata_s4 !== exp) begin
            tests_failed++;
            $display("FAIL b2b_first got ws=%0d d=%h want 3/%h", ws, hrdata_s4, exp);
        end
        sb.push_back(32'hC0DE_000C);
        addr_phase(1'b0, 32'h7000_0030);
        wait_ready(ws);
        exp = sb.pop_front();
        tests_run++;
        if (ws !== 0 || hrdata_s4 !== exp || rd_cycles - r0 !== 3) begin
            tests_failed++;
            $display("FAIL b2b_second got ws=%0d d=%h rd=%0d want 0/%h/3",
                     ws, hrdata_s4, rd_cycles - r0, exp);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        int ws;
        int r0;
        logic [31:0] exp;
        addr_phase(1'b0, 32'h7000_0040);
        @(negedge pll_core_cpuclk);
        tests_run++;
        if (flash_rd !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_pre got rd=%b want 1", flash_rd);
        end
        #2 pad_cpu_rst_b = 1'b0;
        #1;
        tests_run++;
        if ({flash_cs, flash_rd, hready_s4} !== 3'b001) begin
            tests_failed++;
            $display("FAIL rst_mid_async got cs=%b rd=%b rdy=%b want 0/0/1",
                     flash_cs, flash_rd, hready_s4);
        end
        @(negedge pll_core_cpuclk);
        pad_cpu_rst_b = 1'b1;
        next_cycle();
        r0 = rd_cycles;
        sb.push_back(32'hC0DE_0010);
        addr_phase(1'b0, 32'h7000_0040);
        wait_ready(ws);
        exp = sb.pop_front();
        tests_run++;
        if (ws !== 3 || hrdata_s4 !== exp || rd_cycles - r0 !== 3) begin
            tests_failed++;
            $display("FAIL rst_mid_miss got ws=%0d d=%h rd=%0d want 3/%h/3",
                     ws, hrdata_s4, rd_cycles - r0, exp);
        end
        next_cycle();
    endtask

    initial begin
        for (int i = 0; i < 64; i++)
            fmem[i] = 32'hC0DE_0000 | 32'(i);
        fmem[4] = 32'hDEAD_BEEF;
        test_reset();
        test_read_miss_hit();
        test_write();
        test_misalign();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        tests_run++;
        if (sb.size() !== 0) begin
            tests_failed++;
            $display("FAIL scoreboard_left got %0d want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule
